// File: rtl/ksa_if.sv
// rtl/ksa_if.sv - start handshake, key and single-port S-memory bundle for ksa
interface ksa_if #(
  parameter int KEY_BYTES = 3
) ();
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             addr;
  logic [7:0]             rddata;
  logic [7:0]             wrdata;
  logic                   wren;

  // master: sequencer plus S-memory; slave: the key-scheduling engine
  modport master (output en, key, rddata, input rdy, addr, wrdata, wren);
  modport slave  (input en, key, rddata, output rdy, addr, wrdata, wren);
endinterface

// File: rtl/ksa.sv
// rtl/ksa.sv - RC4 key-scheduling permutation over a 256x8 S-memory
// Six cycles per i: read S[i], update j, read S[j], write S[i], write S[j].
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic clk,
  input  logic rst,
  ksa_if.slave bus
);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [7:0]             si_q, si_d;
  logic [KW-1:0]          k_q, k_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             addr_q, addr_d;
  logic [7:0]             wrdata_q, wrdata_d;
  logic                   wren_q, wren_d;
  logic                   rdy_q, rdy_d;
  logic [7:0]             key_byte;

  // key byte 0 is the most-significant byte of the key
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k_q == KW'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    k_d      = k_q;
    key_d    = key_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    rdy_d    = rdy_q;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          key_d   = bus.key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          addr_d  = '0;
          rdy_d   = 1'b0;
          state_d = RD_I;
        end
      end
      RD_I: state_d = LAT_I;
      LAT_I: begin
        si_d    = bus.rddata;
        j_d     = j_q + bus.rddata + key_byte;
        addr_d  = j_d;
        state_d = RD_J;
      end
      RD_J: state_d = LAT_J;
      LAT_J: begin
        // S[j] goes straight into the write-data register for WR_I
        wrdata_d = bus.rddata;
        addr_d   = i_q;
        wren_d   = 1'b1;
        state_d  = WR_I;
      end
      WR_I: begin
        addr_d   = j_q;
        wrdata_d = si_q;
        wren_d   = 1'b1;
        state_d  = WR_J;
      end
      WR_J: begin
        if (i_q == 8'hFF) begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == KW'(KEY_BYTES-1)) ? '0 : k_q + 1'b1;
          addr_d  = i_q + 8'd1;
          state_d = RD_I;
        end
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      si_q     <= '0;
      k_q      <= '0;
      key_q    <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      si_q     <= si_d;
      k_q      <= k_d;
      key_q    <= key_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.rdy    = rdy_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.wren   = wren_q;
endmodule
